// File: rtl/led_scan_driver.sv
// led_scan_driver: time-multiplexed 7-segment scanner with a blanking gap at the start of each digit slot
// Define LED_SCAN_ACTIVE_LOW_EN for active-low (common-anode) SEG_OUT/DIG_OUT drive.
module led_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000,
  parameter int BLANK    = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ENABLE,
  input  logic [8*DIGITS-1:0]   SEG_IN,
  output logic [7:0]            SEG_OUT,
  output logic [DIGITS-1:0]     DIG_OUT,
  output logic                  FRAME
);
`ifdef LED_SCAN_ACTIVE_LOW_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif
  localparam logic [1:0]  S_IDLE    = 2'd0;
  localparam logic [1:0]  S_BLANK   = 2'd1;
  localparam logic [1:0]  S_SHOW    = 2'd2;
  localparam logic [15:0] BLANK_END = 16'(BLANK - 1);
  localparam logic [15:0] SLOT_END  = 16'(PRESCALE - 1);
  localparam logic [2:0]  LAST      = 3'(DIGITS - 1);
  logic [1:0]        state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        seg_q, seg_d;
  logic [DIGITS-1:0] dig_q, dig_d;
  logic              frame_q, frame_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    seg_d   = seg_q;
    dig_d   = dig_q;
    frame_d = 1'b0;
    if (state_q == S_IDLE) begin
      state_d = ENABLE ? S_BLANK : S_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      seg_d   = '0;
      dig_d   = '0;
    end else if (!ENABLE) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      seg_d   = '0;
      dig_d   = '0;
    end else if (state_q == S_BLANK) begin
      cnt_d = cnt_q + 16'd1;
      if (cnt_q == BLANK_END) begin
        state_d = S_SHOW;
        seg_d   = SEG_IN[8*idx_q +: 8];
        dig_d   = DIGITS'(1) << idx_q;
      end
    end else begin
      cnt_d = cnt_q + 16'd1;
      if (cnt_q == SLOT_END) begin
        state_d = S_BLANK;
        cnt_d   = '0;
        seg_d   = '0;
        dig_d   = '0;
        idx_d   = (idx_q == LAST) ? 3'd0 : idx_q + 3'd1;
        frame_d = (idx_q == LAST);
      end
    end
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      seg_q   <= '0;
      dig_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
      frame_q <= frame_d;
    end
  end
  // Polarity is applied after the flops so dark/reset states flip together with lit ones.
  assign SEG_OUT = seg_q ^ {8{INV}};
  assign DIG_OUT = dig_q ^ {DIGITS{INV}};
  assign FRAME   = frame_q;
endmodule

// File: tb/tb_led_scan_driver.sv
// tb_led_scan_driver: cycle-exact scoreboard bench for led_scan_driver (DIGITS=4/PRESCALE=8/BLANK=2 plus a DIGITS=1 instance)
module tb_led_scan_driver;
`ifdef LED_SCAN_ACTIVE_LOW_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif
  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] dig;
    logic       fr;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        en1 = 1'b0;
  logic [31:0] seg_in = 32'h4F5B063F;
  logic [7:0]  seg_out, seg1;
  logic [3:0]  dig_out;
  logic        dig1, frame, frame1;
  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  always #5 clk = ~clk;
  led_scan_driver #(.DIGITS(4), .PRESCALE(8), .BLANK(2)) u_dut (
    .CLK(clk), .RST(rst), .ENABLE(enable), .SEG_IN(seg_in),
    .SEG_OUT(seg_out), .DIG_OUT(dig_out), .FRAME(frame)
  );
  led_scan_driver #(.DIGITS(1), .PRESCALE(2), .BLANK(1)) u_deg (
    .CLK(clk), .RST(rst), .ENABLE(en1), .SEG_IN(seg_in[7:0]),
    .SEG_OUT(seg1), .DIG_OUT(dig1), .FRAME(frame1)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask
  task automatic push_dark(input logic fr);
    sb.push_back('{seg: 8'h00, dig: 4'h0, fr: fr});
  endtask
  task automatic push_lit(input int d, input logic [7:0] s, input int n);
    for (int i = 0; i < n; i++) sb.push_back('{seg: s, dig: 4'(1 << d), fr: 1'b0});
  endtask
  task automatic push_slot(input int d, input logic [7:0] s, input logic fr);
    push_dark(fr);
    push_dark(1'b0);
    push_lit(d, s, 6);
  endtask
  task automatic run(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (sb.size() == 0) begin
        check("sb_empty", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("seg", {24'h0, seg_out}, {24'h0, e.seg ^ {8{INV}}});
        check("dig", {28'h0, dig_out}, {28'h0, e.dig ^ {4{INV}}});
        check("frame", {31'h0, frame}, {31'h0, e.fr});
      end
    end
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_seg"}, {24'h0, seg_out}, {24'h0, {8{INV}}});
    check({tag, "_dig"}, {28'h0, dig_out}, {28'h0, {4{INV}}});
    check({tag, "_frame"}, {31'h0, frame}, 32'h0);
  endtask
  initial begin
    #1 rst = 1'b1;
    #1 check_reset("rst0");
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b1;
    // Frame 1: plain scan order, FRAME closes the frame at the end of digit 3.
    push_slot(0, 8'h3F, 1'b0);
    push_slot(1, 8'h06, 1'b0);
    push_slot(2, 8'h5B, 1'b0);
    push_slot(3, 8'h4F, 1'b0);
    run(32);
    // Frame 2: digit 1's byte changes mid-SHOW but the sampled 0x06 must hold.
    push_slot(0, 8'h3F, 1'b1);
    push_slot(1, 8'h06, 1'b0);
    push_slot(2, 8'h5B, 1'b0);
    push_slot(3, 8'h4F, 1'b0);
    run(13);
    seg_in[15:8] = 8'h7F;
    run(19);
    // Frame 3: new byte on next visit, then async reset mid-SHOW of digit 2.
    push_slot(0, 8'h3F, 1'b1);
    push_slot(1, 8'h7F, 1'b0);
    push_dark(1'b0);
    push_dark(1'b0);
    push_lit(2, 8'h5B, 3);
    run(21);
    rst = 1'b1;
    #1 check_reset("rst_mid");
    @(negedge clk);
    check_reset("rst_hold");
    rst = 1'b0;
    push_slot(0, 8'h3F, 1'b0);
    push_slot(1, 8'h7F, 1'b0);
    push_slot(2, 8'h5B, 1'b0);
    push_slot(3, 8'h4F, 1'b0);
    run(32);
    // Digit 3 is at cnt==7: dropping ENABLE must beat the wrap and suppress FRAME.
    enable = 1'b0;
    push_dark(1'b0);
    push_dark(1'b0);
    push_dark(1'b0);
    run(3);
    enable = 1'b1;
    push_slot(0, 8'h3F, 1'b0);
    push_dark(1'b0);
    push_dark(1'b0);
    push_lit(1, 8'h7F, 2);
    run(12);
    en1 = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk);
      @(negedge clk);
      check("deg_dig", {31'h0, dig1}, {31'h0, (n % 2 == 1) ^ INV});
      check("deg_seg", {24'h0, seg1}, {24'h0, ((n % 2 == 1) ? 8'h3F : 8'h00) ^ {8{INV}}});
      check("deg_frame", {31'h0, frame1}, {31'h0, (n >= 2) && (n % 2 == 0)});
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
